// File: rtl/multi_clock_divider_if.sv
// Configuration port of multi_clock_divider: one write per accepted
// valid/ready handshake, addressed to a channel by cfg_ch.
interface multi_clock_divider_if #(
   parameter int WIDTH = 24
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [3:0]       cfg_ch;
   logic [WIDTH-1:0] cfg_div;
   logic [WIDTH-1:0] cfg_duty;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      output cfg_duty,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      input  cfg_duty,
      output cfg_ready
   );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel reprogrammable clock divider. Each channel produces a
// square wave (slow_clk) and a first-cycle-of-period strobe (tick).
// New settings are held in a shadow and applied only at the channel's
// period boundary (or on the next edge while the channel is disabled).
// Optional feature macro: DIVIDER_DUTY_EN (per-channel high time from
// cfg_duty); without it the high time is half the effective period.
module multi_clock_divider #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 24,
   parameter int RESET_DIV = 12000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] enable,
   multi_clock_divider_if.slave cfg,
   output logic [CHANNELS-1:0] slow_clk,
   output logic [CHANNELS-1:0] tick
);

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

   // Divisors 0 and 1 cannot form a period; they run as 2.
   function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

   logic [CHANNELS-1:0] pending;
   logic                ready;

   assign cfg.cfg_ready = ready;

`ifndef DIVIDER_DUTY_EN
   // cfg_duty has no meaning when the high time follows the period.
   logic unused_duty;
   assign unused_duty = ^cfg.cfg_duty;
`endif

   // Ready reflects the addressed channel's pending flag; out-of-range
   // channel indices are always ready and the write is discarded.
   always_comb begin
      ready = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg.cfg_ch == 4'(i)) ready = !pending[i];
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [WIDTH-1:0] active_div;
      logic [WIDTH-1:0] shadow_div;
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] period;
      logic [WIDTH-1:0] high;
      logic             pend;
      logic             boundary;
      logic             accept;
      logic             apply;
      logic             slow_r;
      logic             tick_r;

      assign period   = eff_period(active_div);
      assign boundary = (cnt == period - WIDTH'(1));
      assign accept   = cfg.cfg_valid && ready && (cfg.cfg_ch == 4'(g));
      // A disabled channel has no period to finish, so it loads at once.
      assign apply    = pend && (boundary || !enable[g]);

      assign pending[g]  = pend;
      assign slow_clk[g] = slow_r;
      assign tick[g]     = tick_r;

`ifdef DIVIDER_DUTY_EN
      logic [WIDTH-1:0] active_high;
      logic [WIDTH-1:0] shadow_high;

      assign high = active_high;

      // Duty shadow/active pair, loaded alongside the divisor.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            active_high <= RST_DIV >> 1;
            shadow_high <= RST_DIV >> 1;
         end else begin
            if (apply)  active_high <= shadow_high;
            if (accept) shadow_high <= cfg.cfg_duty;
         end
      end
`else
      assign high = period >> 1;
`endif

      // Shadow capture on accepted writes and shadow-to-active transfer.
      // Accept needs pend clear and apply needs pend set, so both never
      // fire together; a write landing on a boundary waits a full period.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend       <= 1'b0;
            active_div <= RST_DIV;
            shadow_div <= RST_DIV;
         end else begin
            if (apply) begin
               active_div <= shadow_div;
               pend       <= 1'b0;
            end
            if (accept) begin
               shadow_div <= cfg.cfg_div;
               pend       <= 1'b1;
            end
         end
      end

      // Period counter and registered outputs derived from its state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt    <= '0;
            slow_r <= 1'b0;
            tick_r <= 1'b0;
         end else if (!enable[g]) begin
            cnt    <= '0;
            slow_r <= 1'b0;
            tick_r <= 1'b0;
         end else begin
            slow_r <= (cnt < high);
            tick_r <= (cnt == '0);
            cnt    <= boundary ? '0 : cnt + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider with RESET_DIV = 10.
// Outputs are sampled on the falling edge; traces are packed oldest
// sample first (MSB) and compared with hand-derived bit patterns.
module tb_multi_clock_divider;

   localparam int CH = 4;
   localparam int W  = 24;

   logic          clk;
   logic          rst_n;
   logic [CH-1:0] enable;
   logic [CH-1:0] slow_clk;
   logic [CH-1:0] tick;

   int n_vec = 0;
   int n_err = 0;

   multi_clock_divider_if #(.WIDTH(W)) cfg ();

   multi_clock_divider #(
      .CHANNELS  (CH),
      .WIDTH     (W),
      .RESET_DIV (10)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .cfg      (cfg),
      .slow_clk (slow_clk),
      .tick     (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Record n falling-edge samples of one channel.
   task automatic capture(input int ch, input int n, output logic [63:0] s, output logic [63:0] t);
      s = '0;
      t = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         s = {s[62:0], slow_clk[ch]};
         t = {t[62:0], tick[ch]};
      end
   endtask

`ifdef DIVIDER_DUTY_EN
   // Load ch3 with P=8 and the given duty while idle, run one period.
   task automatic duty_case(input logic [W-1:0] d, input logic [63:0] exp_s);
      logic [63:0] s, t;
      @(negedge clk);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 4'd3;
      cfg.cfg_div   = W'(8);
      cfg.cfg_duty  = d;
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      @(negedge clk);
      enable[3] = 1'b1;
      capture(3, 8, s, t);
      chk($sformatf("duty%0d_slow", d), s, exp_s);
      chk($sformatf("duty%0d_tick", d), t, 64'b10000000);
      enable[3] = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] s, t;
      rst_n         = 1'b0;
      enable        = '0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_ch    = 4'd0;
      cfg.cfg_div   = '0;
      cfg.cfg_duty  = '0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_slow", 64'(slow_clk), 64'h0);
      chk("rst_tick", 64'(tick), 64'h0);
      chk("rst_ready", 64'(cfg.cfg_ready), 64'h1);

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 4'b0001;

      // Reset period 10: 5 high / 5 low, tick every 10.
      capture(0, 20, s, t);
      chk("p10_slow", s, 64'b11111000001111100000);
      chk("p10_tick", t, 64'b10000000001000000000);
      chk("idle_slow", 64'(slow_clk[3:1]), 64'h0);

      // Write accepted on the ch0 boundary edge: one more P=10, then P=4.
      repeat (9) @(negedge clk);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 4'd0;
      cfg.cfg_div   = W'(4);
      #1;
      chk("bnd_ready_pre", 64'(cfg.cfg_ready), 64'h1);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      #1;
      chk("bnd_ready_pend", 64'(cfg.cfg_ready), 64'h0);
      capture(0, 18, s, t);
      chk("bnd_slow", s, 64'b111110000011001100);
      chk("bnd_tick", t, 64'b100000000010001000);

      // ch1 running at P=10, rewritten to 6 mid-period.
      enable = 4'b0011;
      repeat (4) @(negedge clk);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 4'd1;
      cfg.cfg_div   = W'(6);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      #1;
      chk("ch1_ready_pend", 64'(cfg.cfg_ready), 64'h0);
      capture(1, 4, s, t);
      chk("ch1_tail_slow", s, 64'b0000);
      chk("ch1_tail_tick", t, 64'b0000);
      chk("ch1_ready_hold", 64'(cfg.cfg_ready), 64'h0);
      capture(1, 12, s, t);
      chk("ch1_p6_slow", s, 64'b011100011100);
      chk("ch1_p6_tick", t, 64'b010000010000);
      #1;
      chk("ch1_ready_free", 64'(cfg.cfg_ready), 64'h1);

      // Divisor 0 on idle ch2 loads immediately, then runs as P=2.
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 4'd2;
      cfg.cfg_div   = W'(0);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      @(negedge clk);
      enable = 4'b0111;
      capture(2, 6, s, t);
      chk("div0_slow", s, 64'b101010);
      chk("div0_tick", t, 64'b101010);

      // Divisor 1 also runs as P=2.
      cfg.cfg_valid = 1'b1;
      cfg.cfg_div   = W'(1);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      #1;
      chk("div1_ready_pend", 64'(cfg.cfg_ready), 64'h0);
      capture(2, 6, s, t);
      chk("div1_slow", s, 64'b010101);
      chk("div1_tick", t, 64'b010101);

      // Out-of-range channel: always ready, nothing becomes pending.
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 4'd9;
      cfg.cfg_div   = W'(3);
      #1;
      chk("oor_ready", 64'(cfg.cfg_ready), 64'h1);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      for (int k = 0; k < CH; k++) begin
         cfg.cfg_ch = 4'(k);
         #1;
         chk($sformatf("oor_ready_ch%0d", k), 64'(cfg.cfg_ready), 64'h1);
      end
      enable = 4'b0011;

      // Disable mid-run forces ch2 low on the next cycle.
      @(negedge clk);
      chk("dis_slow", 64'(slow_clk[2]), 64'h0);
      chk("dis_tick", 64'(tick[2]), 64'h0);

      // Reset with a pending write on ch1: discarded, back to P=10.
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 4'd1;
      cfg.cfg_div   = W'(4);
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      #1;
      chk("rst2_pend", 64'(cfg.cfg_ready), 64'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst2_slow", 64'(slow_clk), 64'h0);
      chk("rst2_tick", 64'(tick), 64'h0);
      chk("rst2_ready", 64'(cfg.cfg_ready), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      capture(1, 14, s, t);
      chk("rst2_p10_slow", s, 64'b11111000001111);
      chk("rst2_p10_tick", t, 64'b10000000001000);

`ifdef DIVIDER_DUTY_EN
      duty_case(W'(0), 64'b00000000);
      duty_case(W'(3), 64'b11100000);
      duty_case(W'(8), 64'b11111111);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Multi-channel, runtime-reprogrammable clock divider generating CHANNELS independent low-rate square waves plus one-cycle period-start strobes from the single 12 MHz board clock. It sits between the hardware clock and blink/PWM/timing logic. Each channel's divisor (and optionally duty) is loaded through a valid/ready config port. Loads are applied glitch-free at that channel's next period boundary.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16)
- WIDTH, 24: divisor/duty counter width in bits
- RESET_DIV, 12000000: period in clk cycles loaded into every channel at reset (1 Hz at 12 MHz)

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  CHANNELS  per-channel run enable, bit i controls channel i
- cfg_valid  input  1  config write request
- cfg_ready  output  1  config write accepted when cfg_valid && cfg_ready
- cfg_ch  input  4  target channel index
- cfg_div  input  WIDTH  new period in clk cycles
- cfg_duty  input  WIDTH  new high time in clk cycles (used only with DIVIDER_DUTY_EN)
- slow_clk  output  CHANNELS  divided clock per channel, registered
- tick  output  CHANNELS  one-cycle pulse in first cycle of each period, registered

## Operation
- Per channel: active_div, active_high, shadow_div, shadow_high, pending flag, counter cnt[WIDTH-1:0].
- Effective period P = max(active_div, 2); cfg_div values 0 and 1 behave as 2.
- Counter: cnt counts 0..P-1, wraps to 0. Period boundary = cycle where cnt == P-1.
- slow_clk[i] high while cnt < active_high, else low. tick[i] high when cnt == 0.
- active_high clamps: duty 0 -> constantly low; duty >= P -> constantly high (tick still pulses).
- Config: cfg_ready = !pending[cfg_ch] when cfg_ch < CHANNELS; cfg_ready = 1 for out-of-range cfg_ch, write dropped.
- Accepted write stores shadow_div/shadow_high, sets pending.
- At a boundary with pending set: active <= shadow, pending cleared, cnt -> 0; new settings govern the very next period.
- Write accepted in the same cycle as a boundary takes effect at the following boundary, not this one.
- Disabled channel (enable[i]=0): cnt held 0, slow_clk[i]=0, tick[i]=0; pending shadow applied on the next clk edge.
- Enable rising: period starts the cycle after enable is first sampled high; channels enabled on the same edge stay phase-aligned.
- Enable falling mid-period: output forced low on next cycle; no partial-period completion.
- Channels fully independent; simultaneous boundaries on several channels all apply their own pending loads.

## Timing
- Reset (rst_n low, asynchronous): cnt=0, slow_clk=0, tick=0, pending=0, active_div=RESET_DIV, active_high=RESET_DIV>>1; cfg_ready=1.
- Outputs registered: 1-cycle latency from cnt state to pins.
- Write-to-effect latency: from acceptance to new period start = remaining cycles of current period + 1.
- Reset asserted mid-period or with pending write: pending write discarded, channel returns to RESET_DIV.
- Frequency = f_clk / P exactly; no drift across periods.

## Configuration
- DIVIDER_DUTY_EN defined: cfg_duty is stored as shadow_high and sets high time per channel with clamps above.
- Not defined: cfg_duty ignored; shadow_high = cfg_div>>1 (odd P: high floor(P/2), low ceil(P/2)); duty registers removed.

## Test plan
- Reset release, enable=4'b0001, RESET_DIV overridden to 10 -> slow_clk[0] high 5 / low 5 cycles, tick[0] every 10 cycles; other channels low.
- Write ch1 cfg_div=6 while running at P=10 -> cfg_ready low for ch1 until boundary, current period finishes at 10, next periods are 6.
- Write accepted exactly at ch0 boundary -> one more period of old P, then new P.
- DIVIDER_DUTY_EN, cfg_div=8, cfg_duty=0/3/8 -> low always / 3 high 5 low / high always; tick every 8 cycles.
- cfg_div=0 and 1 -> behaves as P=2: alternating high/low, tick every 2 cycles; cfg_ch=9 with CHANNELS=4 -> ready high, no state change.
- Assert rst_n low mid-period with pending write -> outputs 0 immediately, pending cleared, resumes at RESET_DIV after release.
